// File: rtl/alu_rs_pipe_if.sv
// rtl/alu_rs_pipe_if.sv - dispatch, CDB snoop and result handshake bundle for alu_rs_pipe
interface alu_rs_pipe_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             disp_valid;
    logic             disp_ready;
    logic [3:0]       disp_op;
    logic [TAG_W-1:0] disp_dest;
    logic [TAG_W-1:0] disp_tag1;
    logic [XLEN-1:0]  disp_data1;
    logic [TAG_W-1:0] disp_tag2;
    logic [XLEN-1:0]  disp_data2;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;
    logic [XLEN-1:0]  cdb_data;
    logic             out_valid;
    logic             out_ready;
    logic [TAG_W-1:0] out_tag;
    logic [XLEN-1:0]  out_data;
    logic [CW-1:0]    free_count;

    modport master (
        output disp_valid, disp_op, disp_dest, disp_tag1, disp_data1, disp_tag2, disp_data2,
        output cdb_valid, cdb_tag, cdb_data, out_ready,
        input  disp_ready, out_valid, out_tag, out_data, free_count
    );

    modport slave (
        input  disp_valid, disp_op, disp_dest, disp_tag1, disp_data1, disp_tag2, disp_data2,
        input  cdb_valid, cdb_tag, cdb_data, out_ready,
        output disp_ready, out_valid, out_tag, out_data, free_count
    );
endinterface

// File: rtl/alu_rs_pipe.sv
// rtl/alu_rs_pipe.sv - integer ALU reservation station with registered execute and result handshake
module alu_rs_pipe #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input logic         clk,
    input logic         rst,
    input logic         flush,
    alu_rs_pipe_if.slave bus
);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SHW = $clog2(XLEN);

    logic [DEPTH-1:0] r_valid;
    logic [3:0]       r_op    [DEPTH];
    logic [TAG_W-1:0] r_dest  [DEPTH];
    logic [TAG_W-1:0] r_tag1  [DEPTH];
    logic [XLEN-1:0]  r_data1 [DEPTH];
    logic [TAG_W-1:0] r_tag2  [DEPTH];
    logic [XLEN-1:0]  r_data2 [DEPTH];

    logic             r_out_valid;
    logic [TAG_W-1:0] r_out_tag;
    logic [XLEN-1:0]  r_out_data;

    logic [DEPTH-1:0] w_rdy;
    logic             w_issue_hit;
    logic [IW-1:0]    w_issue_idx;
    logic             w_free_hit;
    logic [IW-1:0]    w_free_idx;
    logic [CW-1:0]    w_free_cnt;
    logic             w_issue;
    logic             w_disp;
    logic             w_snoop;
    logic [XLEN-1:0]  w_alu;

    function automatic logic [XLEN-1:0] alu_eval(input logic [3:0] op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
        logic [SHW-1:0] sh;
        sh = b[SHW-1:0];
        case (op)
            4'd0:    alu_eval = a + b;
            4'd1:    alu_eval = a - b;
            4'd2:    alu_eval = a << sh;
            4'd3:    alu_eval = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            4'd4:    alu_eval = {{(XLEN-1){1'b0}}, (a < b)};
            4'd5:    alu_eval = a ^ b;
            4'd6:    alu_eval = a >> sh;
            4'd7:    alu_eval = $unsigned($signed(a) >>> sh);
            4'd8:    alu_eval = a | b;
            4'd9:    alu_eval = a & b;
            default: alu_eval = '0;
        endcase
    endfunction

    // Readiness uses registered tags only, so a CDB capture becomes issuable one cycle later.
    always_comb begin
        w_issue_hit = 1'b0;
        w_issue_idx = '0;
        w_free_hit  = 1'b0;
        w_free_idx  = '0;
        w_free_cnt  = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_rdy[i] = r_valid[i] && (r_tag1[i] == '0) && (r_tag2[i] == '0);
            if (w_rdy[i]) begin
                w_issue_hit = 1'b1;
                w_issue_idx = IW'(i);
            end
            if (!r_valid[i]) begin
                w_free_hit = 1'b1;
                w_free_idx = IW'(i);
            end
            w_free_cnt = w_free_cnt + CW'(~r_valid[i]);
        end
    end

    assign w_issue = w_issue_hit && (!r_out_valid || bus.out_ready);
    assign w_disp  = bus.disp_valid && w_free_hit;
    assign w_snoop = bus.cdb_valid && (bus.cdb_tag != '0);
    assign w_alu   = alu_eval(r_op[w_issue_idx], r_data1[w_issue_idx], r_data2[w_issue_idx]);

    assign bus.disp_ready = w_free_hit;
    assign bus.free_count = w_free_cnt;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_tag    = r_out_tag;
    assign bus.out_data   = r_out_data;

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            r_valid     <= '0;
            r_out_valid <= 1'b0;
            r_out_tag   <= '0;
            r_out_data  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_valid[i] && w_snoop) begin
                    if (r_tag1[i] == bus.cdb_tag) begin
                        r_tag1[i]  <= '0;
                        r_data1[i] <= bus.cdb_data;
                    end
                    if (r_tag2[i] == bus.cdb_tag) begin
                        r_tag2[i]  <= '0;
                        r_data2[i] <= bus.cdb_data;
                    end
                end
            end

            // Dispatch only targets a currently invalid entry, so it never collides with issue or snoop.
            if (w_disp) begin
                r_valid[w_free_idx] <= 1'b1;
                r_op[w_free_idx]    <= bus.disp_op;
                r_dest[w_free_idx]  <= bus.disp_dest;
                if (w_snoop && (bus.disp_tag1 == bus.cdb_tag)) begin
                    r_tag1[w_free_idx]  <= '0;
                    r_data1[w_free_idx] <= bus.cdb_data;
                end else begin
                    r_tag1[w_free_idx]  <= bus.disp_tag1;
                    r_data1[w_free_idx] <= bus.disp_data1;
                end
                if (w_snoop && (bus.disp_tag2 == bus.cdb_tag)) begin
                    r_tag2[w_free_idx]  <= '0;
                    r_data2[w_free_idx] <= bus.cdb_data;
                end else begin
                    r_tag2[w_free_idx]  <= bus.disp_tag2;
                    r_data2[w_free_idx] <= bus.disp_data2;
                end
            end

            if (w_issue) begin
                r_valid[w_issue_idx] <= 1'b0;
                r_out_valid          <= 1'b1;
                r_out_tag            <= r_dest[w_issue_idx];
                r_out_data           <= w_alu;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end
endmodule
